// File: rtl/riscv_pkg.sv
// riscv_pkg: shared datapath widths and writeback source-select encodings.
package riscv_pkg;
   localparam int XLEN       = 32;
   localparam int NREG       = 32;
   localparam int REG_ADDR_W = 5;

   typedef enum logic [1:0] {
      SEL_ALU = 2'b00,
      SEL_MEM = 2'b01,
      SEL_PC4 = 2'b10
   } wb_sel_e;

   // A load always takes memory data; the unused encoding 2'b11 falls back to the ALU.
   function automatic logic [XLEN-1:0] wb_mux(
      input logic            mem_read,
      input logic [1:0]      sel,
      input logic [XLEN-1:0] alu,
      input logic [XLEN-1:0] mem,
      input logic [XLEN-1:0] pc4
   );
      return mem_read ? mem : sel == SEL_PC4 ? pc4 : sel == SEL_MEM ? mem : alu;
   endfunction
endpackage

// File: rtl/regfile_2r1w.sv
// regfile_2r1w: 32x32 two-read/one-write register file with hardwired x0.
// Define WB_REGFILE_BYPASS_EN for same-cycle write-through on the read ports.
module regfile_2r1w
   import riscv_pkg::*;
(
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  we,
   input  logic [REG_ADDR_W-1:0] waddr,
   input  logic [XLEN-1:0]       wdata,
   input  logic [REG_ADDR_W-1:0] raddr1,
   input  logic [REG_ADDR_W-1:0] raddr2,
   output logic [XLEN-1:0]       rdata1,
   output logic [XLEN-1:0]       rdata2
);
   logic [XLEN-1:0] regs [NREG];

   always_ff @(posedge clk) begin
      if (reset) begin
         for (int i = 0; i < NREG; i++) regs[i] <= '0;
      end else if (we && waddr != '0) begin
         regs[waddr] <= wdata;
      end
   end

`ifdef WB_REGFILE_BYPASS_EN
   assign rdata1 = raddr1 == '0 ? '0 : (we && raddr1 == waddr) ? wdata : regs[raddr1];
   assign rdata2 = raddr2 == '0 ? '0 : (we && raddr2 == waddr) ? wdata : regs[raddr2];
`else
   assign rdata1 = raddr1 == '0 ? '0 : regs[raddr1];
   assign rdata2 = raddr2 == '0 ? '0 : regs[raddr2];
`endif
endmodule

// File: rtl/wb_regfile_unit.sv
// wb_regfile_unit: writeback mux, qualified register write and retired-instruction counter.
// Read-port write-through is enabled by defining WB_REGFILE_BYPASS_EN.
module wb_regfile_unit
   import riscv_pkg::*;
(
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  wb_valid,
   input  logic [REG_ADDR_W-1:0] wb_rd,
   input  logic                  wb_reg_write,
   input  logic                  wb_mem_read,
   input  logic [1:0]            wb_output_select,
   input  logic [XLEN-1:0]       wb_alu_result,
   input  logic [XLEN-1:0]       wb_mem_data,
   input  logic [XLEN-1:0]       wb_pc_plus4,
   input  logic [REG_ADDR_W-1:0] rd_addr1,
   input  logic [REG_ADDR_W-1:0] rd_addr2,
   output logic [XLEN-1:0]       rd_data1,
   output logic [XLEN-1:0]       rd_data2,
   output logic [XLEN-1:0]       wb_data,
   output logic                  wb_we,
   output logic [XLEN-1:0]       instret
);
   assign wb_data = wb_mux(wb_mem_read, wb_output_select, wb_alu_result, wb_mem_data, wb_pc_plus4);
   assign wb_we   = wb_valid & wb_reg_write & (wb_rd != '0) & ~reset;

   // Counts every retiring slot, including those that write no register.
   always_ff @(posedge clk) begin
      if (reset) instret <= '0;
      else if (wb_valid) instret <= instret + 1'b1;
   end

   regfile_2r1w u_rf (
      .clk    (clk),
      .reset  (reset),
      .we     (wb_we),
      .waddr  (wb_rd),
      .wdata  (wb_data),
      .raddr1 (rd_addr1),
      .raddr2 (rd_addr2),
      .rdata1 (rd_data1),
      .rdata2 (rd_data2)
   );
endmodule

// File: tb/tb_wb_regfile_unit.sv
// tb_wb_regfile_unit: scoreboard bench for wb_regfile_unit, following WB_REGFILE_BYPASS_EN if defined.
module tb_wb_regfile_unit;
`ifdef WB_REGFILE_BYPASS_EN
   localparam bit BYP = 1'b1;
`else
   localparam bit BYP = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        reset;
   logic        wb_valid, wb_reg_write, wb_mem_read;
   logic [4:0]  wb_rd, rd_addr1, rd_addr2;
   logic [1:0]  wb_output_select;
   logic [31:0] wb_alu_result, wb_mem_data, wb_pc_plus4;
   logic [31:0] rd_data1, rd_data2, wb_data, instret;
   logic        wb_we;

   wb_regfile_unit dut (
      .clk              (clk),
      .reset            (reset),
      .wb_valid         (wb_valid),
      .wb_rd            (wb_rd),
      .wb_reg_write     (wb_reg_write),
      .wb_mem_read      (wb_mem_read),
      .wb_output_select (wb_output_select),
      .wb_alu_result    (wb_alu_result),
      .wb_mem_data      (wb_mem_data),
      .wb_pc_plus4      (wb_pc_plus4),
      .rd_addr1         (rd_addr1),
      .rd_addr2         (rd_addr2),
      .rd_data1         (rd_data1),
      .rd_data2         (rd_data2),
      .wb_data          (wb_data),
      .wb_we            (wb_we),
      .instret          (instret)
   );

   always #5 clk = ~clk;

   typedef struct {
      string       tag;
      logic [31:0] val;
   } exp_t;

   exp_t        sb[$];
   int          n_tests = 0;
   int          n_fail  = 0;
   logic [31:0] m_rf [32];
   logic [31:0] m_instret;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h, want %h", tag, obs, exp);
      end
   endtask

   task automatic push(input string tag, input logic [31:0] v);
      sb.push_back('{tag, v});
   endtask

   task automatic pop(input logic [31:0] obs);
      exp_t e;
      if (sb.size() == 0) begin
         check("sb_underflow", obs, 32'hDEAD_BEEF);
         return;
      end
      e = sb.pop_front();
      check(e.tag, obs, e.val);
   endtask

   function automatic logic [31:0] m_wbdata();
      if (wb_mem_read) return wb_mem_data;
      if (wb_output_select == 2'b01) return wb_mem_data;
      if (wb_output_select == 2'b10) return wb_pc_plus4;
      return wb_alu_result;
   endfunction

   function automatic logic m_we();
      return wb_valid && wb_reg_write && wb_rd != 5'd0 && !reset;
   endfunction

   function automatic logic [31:0] m_read(input logic [4:0] a);
      if (a == 5'd0) return 32'd0;
      if (BYP && m_we() && a == wb_rd) return m_wbdata();
      return m_rf[a];
   endfunction

   // Model-predicted view of every output for the current inputs.
   task automatic observe(input string tag);
      push({tag, ".rd1"}, m_read(rd_addr1));
      push({tag, ".rd2"}, m_read(rd_addr2));
      push({tag, ".wbd"}, m_wbdata());
      push({tag, ".we"}, {31'd0, m_we()});
      push({tag, ".instret"}, m_instret);
      pop(rd_data1);
      pop(rd_data2);
      pop(wb_data);
      pop({31'd0, wb_we});
      pop(instret);
   endtask

   task automatic tick();
      logic        we_s = m_we();
      logic [31:0] d    = m_wbdata();
      logic [4:0]  a    = wb_rd;
      logic        v    = wb_valid;
      logic        r    = reset;
      @(posedge clk);
      if (r) begin
         for (int i = 0; i < 32; i++) m_rf[i] = 32'd0;
         m_instret = 32'd0;
      end else begin
         if (we_s) m_rf[a] = d;
         if (v) m_instret = m_instret + 32'd1;
      end
      #1;
   endtask

   task automatic drive(input logic v, input logic w, input logic [4:0] rd, input logic mr,
                        input logic [1:0] sel, input logic [31:0] alu, input logic [31:0] mem,
                        input logic [31:0] pc4);
      wb_valid = v; wb_reg_write = w; wb_rd = rd; wb_mem_read = mr;
      wb_output_select = sel; wb_alu_result = alu; wb_mem_data = mem; wb_pc_plus4 = pc4;
   endtask

   task automatic read(input logic [4:0] a1, input logic [4:0] a2);
      rd_addr1 = a1;
      rd_addr2 = a2;
      #1;
   endtask

   initial begin
      for (int i = 0; i < 32; i++) m_rf[i] = 32'hx;
      m_instret = 32'hx;
      reset = 1'b1;
      drive(1, 1, 5'd4, 0, 2'b00, 32'h1111_1111, 32'h0, 32'h0);
      read(5'd4, 5'd4);
      push("rst.we", 32'd0);
      pop({31'd0, wb_we});
      tick();
      tick();
      reset = 1'b0;
      drive(0, 0, 5'd0, 0, 2'b00, 32'h0, 32'h0, 32'h0);
      for (int i = 0; i < 32; i++) begin
         read(5'(i), 5'(31 - i));
         push("rst.rd1", 32'd0);
         push("rst.rd2", 32'd0);
         pop(rd_data1);
         pop(rd_data2);
      end
      push("rst.instret", 32'd0);
      pop(instret);

      // x5 <- ALU result
      drive(1, 1, 5'd5, 0, 2'b00, 32'h1234_5678, 32'h0BAD_0BAD, 32'h4);
      read(5'd1, 5'd2);
      observe("x5.pre");
      tick();
      drive(0, 0, 5'd0, 0, 2'b00, 32'h0, 32'h0, 32'h0);
      read(5'd5, 5'd5);
      push("x5.rd1", 32'h1234_5678);
      push("x5.instret", 32'd1);
      pop(rd_data1);
      pop(instret);
      observe("x5.post");

      // write to x0 is discarded
      drive(1, 1, 5'd0, 0, 2'b00, 32'hFFFF_FFFF, 32'h0, 32'h0);
      read(5'd0, 5'd5);
      push("x0.we", 32'd0);
      pop({31'd0, wb_we});
      tick();
      drive(0, 0, 5'd0, 0, 2'b00, 32'h0, 32'h0, 32'h0);
      read(5'd0, 5'd0);
      push("x0.rd1", 32'd0);
      pop(rd_data1);
      observe("x0.post");

      // load overrides select
      drive(1, 1, 5'd7, 1, 2'b00, 32'h1, 32'hCAFE_F00D, 32'h8);
      read(5'd5, 5'd6);
      push("ld.wbd", 32'hCAFE_F00D);
      pop(wb_data);
      tick();
      drive(0, 0, 5'd0, 0, 2'b00, 32'h0, 32'h0, 32'h0);
      read(5'd7, 5'd5);
      push("ld.x7", 32'hCAFE_F00D);
      pop(rd_data1);

      // remaining select codes and non-writing / invalid slots
      drive(1, 1, 5'd10, 0, 2'b01, 32'hAAAA_0001, 32'hBBBB_0002, 32'hCCCC_0003);
      read(5'd10, 5'd7);
      observe("sel01");
      tick();
      drive(1, 1, 5'd11, 0, 2'b10, 32'hAAAA_0011, 32'hBBBB_0012, 32'hCCCC_0013);
      read(5'd11, 5'd10);
      observe("sel10");
      tick();
      drive(1, 1, 5'd12, 0, 2'b11, 32'hAAAA_0021, 32'hBBBB_0022, 32'hCCCC_0023);
      read(5'd12, 5'd11);
      observe("sel11");
      tick();
      drive(1, 0, 5'd13, 0, 2'b00, 32'h1313_1313, 32'h0, 32'h0);
      read(5'd13, 5'd12);
      observe("nowr");
      tick();
      drive(0, 1, 5'd14, 0, 2'b00, 32'h1414_1414, 32'h0, 32'h0);
      read(5'd14, 5'd13);
      observe("inval");
      tick();
      drive(0, 0, 5'd0, 0, 2'b00, 32'h0, 32'h0, 32'h0);
      for (int i = 10; i < 15; i++) begin
         read(5'(i), 5'(i));
         observe("regs");
      end

      // same-cycle write and read of x9 on both ports
      drive(1, 1, 5'd9, 0, 2'b00, 32'hA5A5_A5A5, 32'h0, 32'h0);
      read(5'd9, 5'd9);
      push("byp.rd2", BYP ? 32'hA5A5_A5A5 : 32'h0);
      push("byp.rd1", BYP ? 32'hA5A5_A5A5 : 32'h0);
      pop(rd_data2);
      pop(rd_data1);
      tick();
      drive(0, 0, 5'd0, 0, 2'b00, 32'h0, 32'h0, 32'h0);
      #1;
      push("byp.next.rd1", 32'hA5A5_A5A5);
      push("byp.next.rd2", 32'hA5A5_A5A5);
      pop(rd_data1);
      pop(rd_data2);

      // instret wrap
      force dut.instret = 32'hFFFF_FFFF;
      #1;
      release dut.instret;
      m_instret = 32'hFFFF_FFFF;
      #1;
      push("wrap.pre", 32'hFFFF_FFFF);
      pop(instret);
      drive(1, 0, 5'd0, 0, 2'b00, 32'h0, 32'h0, 32'h0);
      tick();
      drive(0, 0, 5'd0, 0, 2'b00, 32'h0, 32'h0, 32'h0);
      #1;
      push("wrap.post", 32'd0);
      pop(instret);

      // reset wins over a valid write to x3
      drive(1, 1, 5'd3, 0, 2'b00, 32'h11, 32'h0, 32'h0);
      tick();
      reset = 1'b1;
      drive(1, 1, 5'd3, 0, 2'b00, 32'h55, 32'h0, 32'h0);
      read(5'd3, 5'd3);
      push("rstw.we", 32'd0);
      pop({31'd0, wb_we});
      tick();
      reset = 1'b0;
      drive(0, 0, 5'd0, 0, 2'b00, 32'h0, 32'h0, 32'h0);
      read(5'd3, 5'd5);
      push("rstw.x3", 32'd0);
      push("rstw.x5", 32'd0);
      push("rstw.instret", 32'd0);
      pop(rd_data1);
      pop(rd_data2);
      pop(instret);
      observe("rstw.post");

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: got running, want finished");
      $fatal(1, "timeout");
   end
endmodule

// File: doc/wb_regfile_unit.md
WB_REGFILE_UNIT -- requirements
Module: wb_regfile_unit

Interface
REQ-001 The block SHALL use reset reset, synchronous, active-high; clock clk.
REQ-002 Ports SHALL be, clock and reset first:
- clk  in  1  clock
- reset  in  1  synchronous active-high reset
- wb_valid  in  1  MEM/WB slot holds a real instruction
- wb_rd  in  5  destination register
- wb_reg_write  in  1  register write enable
- wb_mem_read  in  1  instruction is a load
- wb_output_select  in  2  writeback source select
- wb_alu_result  in  32  ALU result
- wb_mem_data  in  32  load data
- wb_pc_plus4  in  32  link address
- rd_addr1  in  5  read port 1 address
- rd_addr2  in  5  read port 2 address
- rd_data1  out  32  read port 1 data
- rd_data2  out  32  read port 2 data
- wb_data  out  32  selected writeback value
- wb_we  out  1  qualified write strobe
- instret  out  32  retired-instruction counter

Function
REQ-003 wb_data SHALL be combinational: wb_mem_read=1 -> wb_mem_data, overriding select; otherwise select 00 -> wb_alu_result, 01 -> wb_mem_data, 10 -> wb_pc_plus4, 11 -> wb_alu_result.
REQ-004 wb_we SHALL equal wb_valid & wb_reg_write & (wb_rd != 0) & ~reset.
REQ-005 Register file SHALL be 32 x 32-bit; on posedge clk with wb_we=1, entry wb_rd SHALL take wb_data.
REQ-006 Register x0 SHALL always read 0; writes to x0 SHALL be discarded.
REQ-007 Reads SHALL be combinational: rd_dataN = entry[rd_addrN], subject to REQ-012.
REQ-008 instret SHALL increment by 1 on each posedge where wb_valid=1, whatever wb_reg_write is.
REQ-009 instret SHALL wrap 0xFFFFFFFF -> 0x00000000 with no flag.
REQ-010 Both read ports SHALL be usable on the same address in the same cycle, returning identical data.

Reset
REQ-011 With reset=1 at posedge clk: all 32 entries SHALL clear to 0, instret SHALL clear to 0, and no write or count SHALL occur that cycle, even if wb_valid=1. wb_we SHALL read 0 while reset=1. rd_data1/rd_data2 SHALL read 0 in the cycle after reset.

Configuration
REQ-012 Macro WB_REGFILE_BYPASS_EN, when defined, SHALL give write-through: if wb_we=1 and rd_addrN==wb_rd, rd_dataN SHALL equal wb_data in the same cycle. When undefined, rd_dataN SHALL return the pre-write contents, and the new value SHALL be visible from the next cycle.

Structure
REQ-013 Shared package riscv_pkg SHALL hold XLEN=32, NREG=32, REG_ADDR_W=5 and the output-select encodings: SEL_ALU=2'b00, SEL_MEM=2'b01, SEL_PC4=2'b10.
REQ-014 Storage SHALL be one sub-module, regfile_2r1w, holding the 2-read/1-write array, the x0 rule and the bypass option. The writeback mux and instret SHALL stay in the top module.

Verification
REQ-015 Reset, then read every address on both ports -> all 0; instret=0.
REQ-016 valid=1, write=1, rd=5, select=00, alu=0x12345678 -> next cycle rd_addr1=5 gives 0x12345678; instret=1.
REQ-017 valid=1, write=1, rd=0, alu=0xFFFFFFFF -> wb_we=0; reading x0 gives 0.
REQ-018 mem_read=1, select=00, mem_data=0xCAFEF00D, alu=0x1, rd=7 -> wb_data=0xCAFEF00D; x7=0xCAFEF00D.
REQ-019 Same-cycle write x9=0xA5A5A5A5 and read rd_addr2=9, old x9=0x0 -> 0xA5A5A5A5 with the macro defined, 0x0 without.
REQ-020 Load instret via 0xFFFFFFFF retirements (or force), one more valid -> instret=0. Assert reset together with valid/write to x3=0x55 -> x3 stays 0 and instret=0.
